// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Optional watchdog is enabled by defining RESET_SEQ_WDT_EN (see reset_sequencer.sv).
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_PG = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } seq_state_e;

    localparam int HZ_PER_MHZ = 1000000;
    localparam int MIN_TICKS  = 2;
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 8;

    // Convert a microsecond interval to clock ticks for a whole-MHz clock.
    function automatic int us_to_ticks(input int us, input int clk_hz);
        return us * (clk_hz / HZ_PER_MHZ);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when the stage count and derived tick counts are usable.
    function automatic bit params_valid(input int num_stages, input int clk_hz,
                                        input int d_ticks, input int h_ticks);
        return (num_stages >= MIN_STAGES) && (num_stages <= MAX_STAGES) &&
               ((clk_hz % HZ_PER_MHZ) == 0) &&
               (d_ticks >= MIN_TICKS) && (h_ticks >= MIN_TICKS);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter with a terminal-count flag (count == 0).
// Used for stage/hold timing and, when RESET_SEQ_WDT_EN is defined, the watchdog.
module reset_seq_timer
    import reset_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register, cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: releases NUM_STAGES reset domains in order
// after power-good, and services CPU software reset requests.
// Define RESET_SEQ_WDT_EN to add the wdt_kick/wdt_fired watchdog.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int CLOCK_FREQ_HZ  = 10000000,
    parameter int STAGE_DELAY_US = 100,
    parameter int SW_HOLD_US     = 1000,
    parameter int WDT_TIMEOUT_US = 500000
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  pwr_good,
    input  logic                  sw_rst_req,
`ifdef RESET_SEQ_WDT_EN
    input  logic                  wdt_kick,
    output logic                  wdt_fired,
`endif
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  seq_done,
    output logic                  busy,
    output logic                  sw_rst_ack
);

    localparam int D     = us_to_ticks(STAGE_DELAY_US, CLOCK_FREQ_HZ);
    localparam int H     = us_to_ticks(SW_HOLD_US, CLOCK_FREQ_HZ);
    localparam int W     = us_to_ticks(WDT_TIMEOUT_US, CLOCK_FREQ_HZ);
    localparam int CNT_W = $clog2(max3(D, H, W) + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    // Down-counter reload values: loading N-1 then acting on terminal count
    // gives exactly N edges between the loading edge and the action edge.
    localparam logic [CNT_W-1:0] D_LOAD   = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] H_LOAD   = CNT_W'(H - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    if (!params_valid(NUM_STAGES, CLOCK_FREQ_HZ, D, H)) begin : g_bad_params
        $error("reset_sequencer: NUM_STAGES/CLOCK_FREQ_HZ/delay parameters out of range");
    end

    seq_state_e             state_q, state_d;
    logic [NUM_STAGES-1:0]  rel_q, rel_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   ack_q, ack_d;
    logic                   seq_done_q, seq_done_d;
    logic                   busy_q, busy_d;

    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_load_val;
    logic                   tmr_en;
    logic                   tmr_tc;
    logic                   wdt_timeout;

    reset_seq_timer #(
        .WIDTH(CNT_W)
    ) u_stage_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(W - 1);

    logic wdt_fired_q, wdt_fired_d;
    logic wdt_load;
    logic wdt_tc;

    // Watchdog is held at its start value outside RUN and on every kick.
    assign wdt_load    = (state_q != RUN) || wdt_kick;
    assign wdt_timeout = (state_q == RUN) && !wdt_kick && wdt_tc;

    reset_seq_timer #(
        .WIDTH(CNT_W)
    ) u_wdt_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (wdt_load),
        .load_val (W_LOAD),
        .en       (state_q == RUN),
        .tc       (wdt_tc)
    );

    assign wdt_fired = wdt_fired_q;
`else
    assign wdt_timeout = 1'b0;
`endif

    // Next-state logic: power loss beats everything, then software request, then watchdog.
    always_comb begin
        state_d      = state_q;
        rel_d        = rel_q;
        idx_d        = idx_q;
        ack_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
`ifdef RESET_SEQ_WDT_EN
        wdt_fired_d  = wdt_fired_q;
`endif

        case (state_q)
            WAIT_PG: begin
                rel_d    = '0;
                idx_d    = '0;
                tmr_load = 1'b1;
                if (pwr_good) begin
                    state_d      = RELEASE;
                    tmr_load_val = D_LOAD;
                end
            end

            RELEASE: begin
                if (!pwr_good) begin
                    state_d  = WAIT_PG;
                    rel_d    = '0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    rel_d        = rel_q | (NUM_STAGES'(1) << idx_q);
                    idx_d        = idx_q + IDX_W'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = D_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d      = RUN;
                        tmr_load_val = '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            RUN: begin
                if (!pwr_good) begin
                    state_d  = WAIT_PG;
                    rel_d    = '0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end else if (sw_rst_req || wdt_timeout) begin
                    state_d      = SW_HOLD;
                    rel_d        = '0;
                    idx_d        = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = H_LOAD;
                    ack_d        = sw_rst_req;
`ifdef RESET_SEQ_WDT_EN
                    wdt_fired_d  = wdt_fired_q | (wdt_timeout & ~sw_rst_req);
`endif
                end
            end

            SW_HOLD: begin
                if (!pwr_good) begin
                    state_d  = WAIT_PG;
                    rel_d    = '0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d      = RELEASE;
                    tmr_load     = 1'b1;
                    tmr_load_val = D_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d  = WAIT_PG;
                rel_d    = '0;
                idx_d    = '0;
                tmr_load = 1'b1;
            end
        endcase

        seq_done_d = (state_d == RUN);
        busy_d     = (state_d != RUN);
    end

    // State and registered outputs, forced to their held-in-reset values by rst_n.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= WAIT_PG;
            rel_q      <= '0;
            idx_q      <= '0;
            ack_q      <= 1'b0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rel_q      <= rel_d;
            idx_q      <= idx_d;
            ack_q      <= ack_d;
            seq_done_q <= seq_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    // Sticky watchdog cause flag; only rst_n clears it so firmware can read it after recovery.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_fired_q <= wdt_fired_d;
        end
    end
`endif

    assign rst_out_n  = rel_q;
    assign seq_done   = seq_done_q;
    assign busy       = busy_q;
    assign sw_rst_ack = ack_q;

endmodule
